// File: rtl/keypad_hex_scan_pkg.sv
// Shared types and helpers for the 4x4 hex keypad scanner: FSM states,
// frame-result encoding, the key map and the minimum legal parameter values.
package keypad_pkg;

  localparam int MIN_SCAN_DIV  = 4;
  localparam int MIN_DB_FRAMES = 1;
  localparam int MIN_REPEAT    = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_CHK,
    ST_HELD,
    ST_RELEASE_CHK
  } scan_state_e;

  // Outcome of one full scan frame.
  typedef enum logic [1:0] {
    RES_NONE,
    RES_ONE,
    RES_MULTI
  } frame_res_e;

  // Row r (top to bottom), column c (left to right) to hex code.
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'hE;
      4'b11_01: code = 4'h0;
      4'b11_10: code = 4'hF;
      default:  code = 4'hD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_hex_scan_if.sv
// Keypad-side and key-output signals of the scanner. master = scanner side,
// slave = keypad/consumer side.
interface keypad_hex_scan_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key;
  logic       key_tick;
  logic       key_held;
  logic       multi_key;

  modport master (
    input  row,
    output col, key, key_tick, key_held, multi_key
  );

  modport slave (
    output row,
    input  col, key, key_tick, key_held, multi_key
  );
endinterface

// File: rtl/keypad_hex_scan_sync_2ff.sv
// Two-flop synchronizer of parameterized width for asynchronous inputs.
module sync_2ff #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two-stage capture of the asynchronous input.
  // NOTE: non-blocking assignments make both stages sample the old values, so this really is two flops.
  always_ff @(posedge clk) begin
    if (!reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_hex_scan.sv
// 4x4 hex keypad scanner: strobes one column at a time, samples the rows at
// the end of each column window, debounces over whole frames and issues a
// registered hex code with a one-cycle key_tick.
// Optional feature: define KEYPAD_AUTOREPEAT_EN for auto-repeat while held.
module keypad_hex_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int DB_FRAMES    = 4,
  parameter int REPEAT_DELAY = 32,
  parameter int REPEAT_RATE  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  keypad_hex_scan_if.master     bus
);

  localparam int DIVW = $clog2(SCAN_DIV);
  localparam int DBW  = $clog2(DB_FRAMES + 1);

  if (SCAN_DIV < MIN_SCAN_DIV) begin : g_bad_scan_div
    $error("SCAN_DIV below minimum");
  end
  if (DB_FRAMES < MIN_DB_FRAMES) begin : g_bad_db_frames
    $error("DB_FRAMES below minimum");
  end
  if (REPEAT_DELAY < MIN_REPEAT || REPEAT_RATE < MIN_REPEAT) begin : g_bad_repeat
    $error("REPEAT_DELAY/REPEAT_RATE below minimum");
  end

  // ---------------- row synchronizer ----------------
  logic [3:0] row_s;

  sync_2ff #(.WIDTH(4), .RST_VAL(4'hF)) u_row_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.row),
    .q     (row_s)
  );

  // ---------------- column scan ----------------
  logic [DIVW-1:0] div_cnt;
  logic [1:0]      col_idx;
  logic            sample;
  logic            frame_end;

  assign sample    = (div_cnt == DIVW'(SCAN_DIV - 1));
  assign frame_end = sample && (col_idx == 2'd3);
  assign bus.col   = ~(4'b0001 << col_idx);

  // Column window timer; the column advances right after its sample cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt <= '0;
      col_idx <= 2'd0;
    end else if (sample) begin
      div_cnt <= '0;
      col_idx <= col_idx + 2'd1;
    end else begin
      div_cnt <= div_cnt + DIVW'(1);
    end
  end

  // ---------------- per-frame accumulators ----------------
  logic [1:0] acc_cnt;
  logic [3:0] acc_code;
  logic [1:0] win_cnt;
  logic [3:0] win_code;
  frame_res_e res;

  // Fold the current column's pressed rows into the running frame totals.
  // NOTE: every variable gets a default first so no path leaves one unassigned and infers a latch.
  always_comb begin
    win_cnt  = acc_cnt;
    win_code = acc_code;
    for (int r = 0; r < 4; r++) begin
      if (!row_s[r]) begin
        if (win_cnt != 2'd2) win_cnt = win_cnt + 2'd1;
        win_code = key_map(2'(r), col_idx);
      end
    end
    case (win_cnt)
      2'd0:    res = RES_NONE;
      2'd1:    res = RES_ONE;
      default: res = RES_MULTI;
    endcase
  end

  // Accumulate at each sample; the frame-end sample clears for the next frame.
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_cnt  <= 2'd0;
      acc_code <= 4'h0;
    end else if (frame_end) begin
      acc_cnt  <= 2'd0;
      acc_code <= 4'h0;
    end else if (sample) begin
      acc_cnt  <= win_cnt;
      acc_code <= win_code;
    end
  end

  // ---------------- debounce FSM ----------------
  scan_state_e    state, state_d;
  logic [DBW-1:0] cnt, cnt_d;
  logic [3:0]     cand, cand_d;
  logic [3:0]     key_q, key_d;
  logic           tick_q, tick_d;
  logic           multi_q, multi_d;
  logic           one_match_cand;
  logic           one_match_key;

  assign one_match_cand = (res == RES_ONE) && (win_code == cand);
  assign one_match_key  = (res == RES_ONE) && (win_code == key_q);

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RPW = $clog2(((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE) + 1);
  logic [RPW-1:0] rep_cnt, rep_cnt_d;
  logic           rep_first, rep_first_d;
  logic [RPW-1:0] rep_target;

  assign rep_target = rep_first ? RPW'(REPEAT_DELAY) : RPW'(REPEAT_RATE);
`endif

  // Next-state and output decode, evaluated once per frame end.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    cand_d  = cand;
    key_d   = key_q;
    tick_d  = 1'b0;
    multi_d = multi_q;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_cnt_d   = rep_cnt;
    rep_first_d = rep_first;
`endif
    if (frame_end) begin
      multi_d = (res == RES_MULTI);
      case (state)
        ST_IDLE: begin
          if (res == RES_ONE) begin
            cand_d = win_code;
            if (DB_FRAMES == 1) begin
              key_d   = win_code;
              tick_d  = 1'b1;
              cnt_d   = '0;
              state_d = ST_HELD;
            end else begin
              cnt_d   = DBW'(1);
              state_d = ST_PRESS_CHK;
            end
          end
        end
        ST_PRESS_CHK: begin
          if (one_match_cand) begin
            if (cnt + DBW'(1) == DBW'(DB_FRAMES)) begin
              key_d   = cand;
              tick_d  = 1'b1;
              cnt_d   = '0;
              state_d = ST_HELD;
            end else begin
              cnt_d = cnt + DBW'(1);
            end
          end else if (res == RES_ONE) begin
            cand_d = win_code;
            cnt_d  = DBW'(1);
          end else begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end
        end
        ST_HELD: begin
          if (one_match_key) begin
`ifdef KEYPAD_AUTOREPEAT_EN
            if (rep_cnt + RPW'(1) == rep_target) begin
              tick_d      = 1'b1;
              rep_cnt_d   = '0;
              rep_first_d = 1'b0;
            end else begin
              rep_cnt_d = rep_cnt + RPW'(1);
            end
`endif
          end else if (res != RES_MULTI) begin
            if (DB_FRAMES == 1) begin
              cnt_d   = '0;
              state_d = ST_IDLE;
            end else begin
              cnt_d   = DBW'(1);
              state_d = ST_RELEASE_CHK;
            end
          end
        end
        default: begin // ST_RELEASE_CHK
          if (one_match_key) begin
            cnt_d   = '0;
            state_d = ST_HELD;
          end else if (cnt + DBW'(1) == DBW'(DB_FRAMES)) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt + DBW'(1);
          end
        end
      endcase
    end
`ifdef KEYPAD_AUTOREPEAT_EN
    if (state_d != ST_HELD) begin
      rep_cnt_d   = '0;
      rep_first_d = 1'b1;
    end
`endif
  end

  // FSM state, debounce counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      cand    <= 4'h0;
      key_q   <= 4'h0;
      tick_q  <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      cand    <= cand_d;
      key_q   <= key_d;
      tick_q  <= tick_d;
      multi_q <= multi_d;
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  // Auto-repeat frame counter; only advances while held on a single key.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
    end else begin
      rep_cnt   <= rep_cnt_d;
      rep_first <= rep_first_d;
    end
  end
`endif

  assign bus.key       = key_q;
  assign bus.key_tick  = tick_q;
  assign bus.multi_key = multi_q;
  assign bus.key_held  = (state == ST_HELD) || (state == ST_RELEASE_CHK);

endmodule

// File: tb/tb_keypad_hex_scan.sv
// Directed bench for keypad_hex_scan with SCAN_DIV=4, DB_FRAMES=2 (16-cycle
// frames). A keypad model drives rows from the strobed column; a monitor
// records ticks. Define KEYPAD_AUTOREPEAT_EN to run the auto-repeat case.
module tb_keypad_hex_scan;

  localparam int SCAN_DIV = 4;
  localparam int DB       = 2;
  localparam int FRAME    = 4 * SCAN_DIV;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  keypad_hex_scan_if kp ();

  keypad_hex_scan #(
    .SCAN_DIV     (SCAN_DIV),
    .DB_FRAMES    (DB),
    .REPEAT_DELAY (3),
    .REPEAT_RATE  (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (kp)
  );

  // pressed[r] bit c = switch at row r, column c closed.
  logic [3:0] pressed [4];

  always_comb begin
    logic [3:0] rv;
    rv = 4'hF;
    for (int r = 0; r < 4; r++) rv[r] = ~|(pressed[r] & ~kp.col);
    kp.row = rv;
  end

  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  int         tick_cnt = 0;
  logic [3:0] tick_key = 4'h0;
  int         tick_time[$];
  logic [3:0] tick_keys[$];
  logic [3:0] prev_key = 4'h0;
  int         bad_key_change = 0;
  int         bad_col = 0;
  logic       rst_seen = 1'b1;

  always @(posedge clk) rst_seen <= !reset;

  always @(negedge clk) begin
    cyc++;
    if (kp.key_tick) begin
      tick_cnt++;
      tick_key = kp.key;
      tick_time.push_back(cyc);
      tick_keys.push_back(kp.key);
    end
    if (kp.key != prev_key && !kp.key_tick && !rst_seen) bad_key_change++;
    if ($countones(~kp.col) != 1) bad_col++;
    prev_key = kp.key;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_col"},   32'(kp.col),       32'hE);
    check({tag, "_key"},   32'(kp.key),       32'h0);
    check({tag, "_tick"},  32'(kp.key_tick),  32'h0);
    check({tag, "_held"},  32'(kp.key_held),  32'h0);
    check({tag, "_multi"}, 32'(kp.multi_key), 32'h0);
  endtask

  task automatic release_all();
    for (int r = 0; r < 4; r++) pressed[r] = 4'h0;
  endtask

  initial begin
    release_all();
    reset = 1'b0;
    cycles(3);
    check_reset_vals("rst");
    reset = 1'b1;

`ifdef KEYPAD_AUTOREPEAT_EN
    // Hold r2/c3: ticks at acceptance, +3 frames, then every 2 frames.
    tick_cnt = 0;
    tick_time.delete();
    tick_keys.delete();
    pressed[2] = 4'b1000;
    cycles(12 * FRAME);
    check("rep_count_ge4", 32'(tick_time.size() >= 4), 32'h1);
    if (tick_time.size() >= 4) begin
      check("rep_gap_delay", 32'(tick_time[1] - tick_time[0]), 32'(3 * FRAME));
      check("rep_gap_rate1", 32'(tick_time[2] - tick_time[1]), 32'(2 * FRAME));
      check("rep_gap_rate2", 32'(tick_time[3] - tick_time[2]), 32'(2 * FRAME));
      for (int i = 0; i < 4; i++) check("rep_key", 32'(tick_keys[i]), 32'hC);
    end
    check("rep_held", 32'(kp.key_held), 32'h1);
`else
    // Contact bouncing every frame never debounces.
    tick_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      pressed[0] = (i % 2 == 0) ? 4'b0010 : 4'b0000;
      cycles(FRAME);
    end
    check("bounce_ticks", 32'(tick_cnt), 32'h0);
    check("bounce_key",   32'(kp.key),   32'h0);
    release_all();
    cycles(3 * FRAME);

    // Stable press r1/c2 -> single tick, key 6.
    tick_cnt = 0;
    pressed[1] = 4'b0100;
    cycles(FRAME);
    check("press_early", 32'(tick_cnt), 32'h0);
    cycles(2 * FRAME);
    check("press_ticks",    32'(tick_cnt),    32'h1);
    check("press_tick_key", 32'(tick_key),    32'h6);
    check("press_key",      32'(kp.key),      32'h6);
    check("press_held",     32'(kp.key_held), 32'h1);
    cycles(10 * FRAME);
    check("press_no_repeat", 32'(tick_cnt), 32'h1);

    // Release: key_held needs two NONE frames.
    release_all();
    cycles(FRAME);
    check("rel_held_early", 32'(kp.key_held), 32'h1);
    cycles(2 * FRAME);
    check("rel_held",  32'(kp.key_held), 32'h0);
    check("rel_key",   32'(kp.key),      32'h6);
    check("rel_ticks", 32'(tick_cnt),    32'h1);

    // Two keys: MULTI, no tick; drop one -> tick for the remaining key.
    tick_cnt = 0;
    pressed[0] = 4'b0001;
    pressed[2] = 4'b1000;
    cycles(40);
    check("multi_flag",  32'(kp.multi_key), 32'h1);
    check("multi_ticks", 32'(tick_cnt),     32'h0);
    pressed[2] = 4'b0000;
    cycles(3 * FRAME);
    check("multi_rel_ticks", 32'(tick_cnt),     32'h1);
    check("multi_rel_key",   32'(kp.key),       32'h1);
    check("multi_rel_flag",  32'(kp.multi_key), 32'h0);

    // Full release, then re-press r3/c1 -> key 0.
    release_all();
    cycles(3 * FRAME);
    check("multi_done_held", 32'(kp.key_held), 32'h0);
    tick_cnt = 0;
    pressed[3] = 4'b0010;
    cycles(3 * FRAME);
    check("repress_ticks", 32'(tick_cnt),    32'h1);
    check("repress_key",   32'(kp.key),      32'h0);
    check("repress_held",  32'(kp.key_held), 32'h1);

    // Reset while holding r2/c0 (key 7): fresh press afterwards.
    release_all();
    cycles(3 * FRAME);
    pressed[2] = 4'b0001;
    cycles(3 * FRAME);
    check("pre_rst_key", 32'(kp.key), 32'h7);
    reset = 1'b0;
    cycles(1);
    check_reset_vals("midrst");
    reset = 1'b1;
    tick_cnt = 0;
    cycles(FRAME);
    check("post_rst_early", 32'(tick_cnt), 32'h0);
    cycles(2 * FRAME);
    check("post_rst_ticks", 32'(tick_cnt),    32'h1);
    check("post_rst_key",   32'(kp.key),      32'h7);
    check("post_rst_held",  32'(kp.key_held), 32'h1);
`endif

    check("key_only_on_tick", 32'(bad_key_change), 32'h0);
    check("col_one_hot",      32'(bad_col),        32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
